// File: rtl/moore_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : moore_fsm_if
// Description : Serial bit-stream bundle for the moore_fsm sequence detector.
//               The "master" side drives the serial bit and observes the
//               detection flag; the "slave" side is the detector itself.
// Signals     : in  - serial data bit, sampled by the detector on rising clk
//               out - one-cycle detection flag produced by the detector
// Revision    : 1.0 - initial release
// ============================================================================
interface moore_fsm_if;
  logic in;
  logic out;

  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );
endinterface
`default_nettype wire

// File: rtl/moore_fsm.sv
`default_nettype none
// ============================================================================
// Module      : moore_fsm
// Description : Moore serial sequence detector, non-overlapping. Counts how
//               many leading bits of the pattern SEQ (MSB first) have been
//               matched and raises out for one cycle once all SEQ_LEN bits
//               have arrived. Mismatches fall back along the KMP failure
//               chain, so partial matches that restart inside the pattern
//               are not lost.
// Ports       : clk      - system clock, rising-edge active
//               rst      - asynchronous active-low reset
//               bus.in   - serial data bit (slave modport input)
//               bus.out  - detection flag, decoded from state only
// Parameters  : SEQ_LEN  - pattern length, 2..16
//               SEQ      - pattern, first expected bit in the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module moore_fsm #(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] SEQ     = 3'b101
) (
  input  wire logic  clk,
  input  wire logic  rst,
  moore_fsm_if.slave bus
);

  // State holds the match count k (0 = IDLE, SEQ_LEN = DETECT).
  localparam int                 STATE_W   = $clog2(SEQ_LEN + 1);
  localparam int                 NUM_CODES = 1 << STATE_W;
  localparam logic [STATE_W-1:0] S_IDLE    = '0;
  localparam logic [STATE_W-1:0] S_DETECT  = STATE_W'(SEQ_LEN);

  // --------------------------------------------------------------------------
  // Next match count from count k_in on bit b. Evaluated only with constant
  // arguments, so the whole transition table folds to constants.
  //   - DETECT (and any unused code) behaves like IDLE: a completed match
  //     contributes no bits to the next one.
  //   - On a hit the count simply advances.
  //   - On a miss, search the longest prefix of length j <= k whose last bit
  //     equals b and whose first j-1 bits equal the last j-1 matched bits.
  // Pattern bit p[i] lives at SEQ[SEQ_LEN-1-i].
  // --------------------------------------------------------------------------
  function automatic logic [STATE_W-1:0] next_count(input int k_in, input logic b);
    int   k;
    int   result;
    logic found;
    logic ok;
    k      = (k_in >= SEQ_LEN) ? 0 : k_in;
    result = 0;
    found  = 1'b0;
    if (SEQ[SEQ_LEN-1-k] == b) begin
      result = k + 1;
      found  = 1'b1;
    end
    for (int j = k; j >= 1; j--) begin
      if (!found) begin
        // candidate's last bit p[j-1] must equal the new bit
        ok = (SEQ[SEQ_LEN-j] == b);
        // p[0..j-2] must equal the tail p[k-j+1..k-1] of what was matched
        for (int i = 0; i < j - 1; i++) begin
          if (SEQ[SEQ_LEN-1-i] != SEQ[SEQ_LEN-k+j-2-i]) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          result = j;
          found  = 1'b1;
        end
      end
    end
    return STATE_W'(result);
  endfunction

  // Full transition table, indexed by every code the state register can hold.
  // Unused codes (above SEQ_LEN) steer back into the legal range.
  logic [STATE_W-1:0] next_on0 [NUM_CODES];
  logic [STATE_W-1:0] next_on1 [NUM_CODES];

  for (genvar g = 0; g < NUM_CODES; g++) begin : g_next_tab
    assign next_on0[g] = next_count(g, 1'b0);
    assign next_on1[g] = next_count(g, 1'b1);
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               detect;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.in) begin
      state_d = next_on1[state_q];
    end else begin
      state_d = next_on0[state_q];
    end
  end

  // Output logic: depends on the registered state only
  always_comb begin
    detect = 1'b0;
    if (state_q == S_DETECT) begin
      detect = 1'b1;
    end
  end

  assign bus.out = detect;

endmodule
`default_nettype wire

// File: tb/tb_moore_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_fsm
// Description : Self-checking bench for moore_fsm. Two instances run side by
//               side on the same clock and reset: pattern "101" (3 bits) and
//               pattern "1101" (4 bits). Directed vectors carry hand-computed
//               expected flags; a random phase compares against a
//               history-based model of non-overlapping detection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  moore_fsm_if bus3();
  moore_fsm_if bus4();

  moore_fsm #(.SEQ_LEN(3), .SEQ(3'b101)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  moore_fsm #(.SEQ_LEN(4), .SEQ(4'b1101)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one bit to each detector, then move just past the sampling edge.
  task automatic step(input logic b3, input logic b4);
    @(negedge clk);
    bus3.in = b3;
    bus4.in = b4;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges while in toggles; both flags must stay low.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus3.in = ~bus3.in;
      bus4.in = ~bus4.in;
      @(posedge clk);
      #1;
      check_bit($sformatf("%s_hold3_c%0d", tag, c), bus3.out, 1'b0);
      check_bit($sformatf("%s_hold4_c%0d", tag, c), bus4.out, 1'b0);
    end
    @(negedge clk);
    rst     = 1'b1;
    bus3.in = 1'b0;
    bus4.in = 1'b0;
  endtask

  // bits/exp are read from index n-1 (first bit) down to 0 (last bit).
  task automatic run_vec(input string tag, input int n, input logic [31:0] bits,
                         input logic [31:0] exp3, input logic [31:0] exp4);
    do_reset(tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], bits[i]);
      check_bit($sformatf("%s_p101_b%0d", tag, n - i), bus3.out, exp3[i]);
      check_bit($sformatf("%s_p1101_b%0d", tag, n - i), bus4.out, exp4[i]);
    end
  endtask

  // Longest suffix of the history since the last match that is also a prefix
  // of the pattern. hist[0] is the newest bit.
  function automatic int model_k(input logic [15:0] hist, input int hlen,
                                 input int len, input logic [15:0] pat);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j <= len && j <= hlen; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (hist[j-1-i] != pat[len-1-i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] h3, h4;
    int          l3, l4, k3, k4;
    logic        b3, b4, e3, e4;

    bus3.in = 1'b0;
    bus4.in = 1'b0;

    // Power-on: reset held low from time 0
    @(posedge clk);
    #1;
    check_bit("por_out3", bus3.out, 1'b0);
    check_bit("por_out4", bus4.out, 1'b0);

    // Reset held with in toggling, then async assert mid-cycle from S2
    do_reset("rst");
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clk);
    bus3.in = 1'b1;
    bus4.in = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_bit("async_s2_pre_edge3", bus3.out, 1'b0);
    @(posedge clk);
    #1;
    // without the reset, this edge would have completed "101"
    check_bit("async_s2_held3", bus3.out, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    bus3.in = 1'b0;
    bus4.in = 1'b0;
    step(1'b1, 1'b1);
    check_bit("post_rst_b1_3", bus3.out, 1'b0);

    // Async reset from DETECT: flag must drop with no clock edge
    do_reset("rstdet");
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check_bit("det_before_rst3", bus3.out, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_bit("det_async_drop3", bus3.out, 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    bus3.in = 1'b0;
    bus4.in = 1'b0;

    // Directed vectors (first bit on the left)
    run_vec("basic",      4, 32'b1010,    32'b0010,    32'b0000);
    run_vec("nonovl",     7, 32'b1010101, 32'b0010001, 32'b0000000);
    run_vec("s1loop",     4, 32'b1101,    32'b0001,    32'b0001);
    run_vec("s2miss",     4, 32'b1001,    32'b0000,    32'b0000);
    run_vec("b2b",        6, 32'b101101,  32'b001001,  32'b000001);
    run_vec("nonovl4",    7, 32'b1101101, 32'b0001001, 32'b0001000);
    run_vec("kmpfall",    5, 32'b11101,   32'b00001,   32'b00001);

    // Random stream against the reference model, both patterns at once
    do_reset("rand");
    h3 = '0; h4 = '0; l3 = 0; l4 = 0;
    for (int c = 0; c < 200; c++) begin
      b3 = 1'($urandom_range(0, 1));
      b4 = 1'($urandom_range(0, 1));
      step(b3, b4);
      h3 = {h3[14:0], b3};
      h4 = {h4[14:0], b4};
      if (l3 < 16) l3++;
      if (l4 < 16) l4++;
      k3 = model_k(h3, l3, 3, 16'h0005);
      k4 = model_k(h4, l4, 4, 16'h000D);
      e3 = (k3 == 3);
      e4 = (k4 == 4);
      if (e3) l3 = 0;
      if (e4) l4 = 0;
      check_bit($sformatf("rand_p101_c%0d", c), bus3.out, e3);
      check_bit($sformatf("rand_p1101_c%0d", c), bus4.out, e4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
